// File: rtl/vga_pkg.sv
// Shared VGA constants, colour and mode encodings, and glyph stroke patterns
// used by the digit sprite renderer.
package vga_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIX_W    = 10;

  localparam logic [2:0] RGB_BLACK   = 3'b000;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_XBOUNCE = 2'b01,
    MODE_YBOUNCE = 2'b10,
    MODE_DIAG    = 2'b11
  } mode_e;

  // Seven-segment style strokes on a 32-pixel row; MSB is the leftmost pixel.
  localparam logic [31:0] SEG_NONE = 32'h0000_0000;
  localparam logic [31:0] SEG_H    = 32'h000F_F000;
  localparam logic [31:0] SEG_L    = 32'h0030_0000;
  localparam logic [31:0] SEG_R    = 32'h0000_0C00;
  localparam logic [31:0] SEG_LR   = SEG_L | SEG_R;

  typedef struct packed {
    logic             bounce;
    logic             neg;
    logic [PIX_W-1:0] pos;
  } axis_t;

endpackage

// File: rtl/digit_glyph_rom.sv
// Combinational glyph ROM: one row of a 32x16 digit glyph (0-9), blank for 10-15.
module digit_glyph_rom
  import vga_pkg::*;
#(
  parameter int SPRITE_W = 32
) (
  input  logic [3:0]          digit,
  input  logic [3:0]          row,
  output logic [SPRITE_W-1:0] row_data
);

  logic [31:0] glyph;

  // Rows: 0 top bar, 1-6 upper strokes, 7 middle bar, 8-14 lower strokes, 15 bottom bar.
  function automatic logic [31:0] pick(input logic [3:0] r,
                                       input logic [31:0] top,
                                       input logic [31:0] up,
                                       input logic [31:0] mid,
                                       input logic [31:0] lo,
                                       input logic [31:0] bot);
    logic [31:0] v;
    case (r)
      4'd0:                                 v = top;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6:   v = up;
      4'd7:                                 v = mid;
      4'd15:                                v = bot;
      default:                              v = lo;
    endcase
    return v;
  endfunction

  always_comb begin
    glyph = '0;
    case (digit)
      4'd0:    glyph = pick(row, SEG_H,    SEG_LR, SEG_NONE, SEG_LR, SEG_H);
      4'd1:    glyph = pick(row, SEG_NONE, SEG_R,  SEG_NONE, SEG_R,  SEG_NONE);
      4'd2:    glyph = pick(row, SEG_H,    SEG_R,  SEG_H,    SEG_L,  SEG_H);
      4'd3:    glyph = pick(row, SEG_H,    SEG_R,  SEG_H,    SEG_R,  SEG_H);
      4'd4:    glyph = pick(row, SEG_NONE, SEG_LR, SEG_H,    SEG_R,  SEG_NONE);
      4'd5:    glyph = pick(row, SEG_H,    SEG_L,  SEG_H,    SEG_R,  SEG_H);
      4'd6:    glyph = pick(row, SEG_H,    SEG_L,  SEG_H,    SEG_LR, SEG_H);
      4'd7:    glyph = pick(row, SEG_H,    SEG_R,  SEG_NONE, SEG_R,  SEG_NONE);
      4'd8:    glyph = pick(row, SEG_H,    SEG_LR, SEG_H,    SEG_LR, SEG_H);
      4'd9:    glyph = pick(row, SEG_H,    SEG_LR, SEG_H,    SEG_R,  SEG_H);
      default: glyph = '0;
    endcase
  end

  assign row_data = SPRITE_W'(glyph);

endmodule

// File: rtl/digit_sprite_engine.sv
// Digit sprite renderer: static or bouncing 32x16 glyph, pixel output one clock
// behind pix_x/pix_y, position and direction updated once per frame.
module digit_sprite_engine #(
  parameter int         SPRITE_W = 32,
  parameter int         SPRITE_H = 16,
  parameter int         SCREEN_W = vga_pkg::SCREEN_W,
  parameter int         SCREEN_H = vga_pkg::SCREEN_H,
  parameter int         X_INIT   = 300,
  parameter int         Y_INIT   = 10,
  parameter int         STEP     = 1,
  parameter logic [2:0] COLOR    = vga_pkg::RGB_MAGENTA
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_on,
  input  logic                      refr_tick,
  input  logic [vga_pkg::PIX_W-1:0] pix_x,
  input  logic [vga_pkg::PIX_W-1:0] pix_y,
  input  logic [3:0]                digit,
  input  logic [1:0]                mode,
  input  logic                      go_home,
  output logic                      sprite_on,
  output logic [2:0]                sprite_rgb,
  output logic [vga_pkg::PIX_W-1:0] x_pos,
  output logic [vga_pkg::PIX_W-1:0] y_pos,
  output logic                      hit
);

  import vga_pkg::*;

  localparam int         COL_W  = $clog2(SPRITE_W);
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [PIX_W-1:0] X_HOME = PIX_W'(X_INIT);
  localparam logic [PIX_W-1:0] Y_HOME = PIX_W'(Y_INIT);

  logic [PIX_W-1:0] x_q, y_q;
  logic             dx_neg_q, dy_neg_q;
  logic [3:0]       digit_q;
  logic             hit_q, sprite_on_q;
  logic [2:0]       rgb_q;

  mode_e            mode_w;
  logic             move_x, move_y;
  axis_t            ax_d, ay_d;
  logic             sprite_on_d;
  logic [10:0]      col_off, row_off;
  logic             in_box;
  logic [COL_W-1:0] col_idx;
  logic [SPRITE_W-1:0] rom_row;

  // One axis step in 11-bit arithmetic so neither the +STEP overshoot nor the
  // -STEP underflow can wrap before the limit test.
  function automatic axis_t axis_next(input logic [PIX_W-1:0] pos,
                                      input logic             neg,
                                      input logic [10:0]      lim);
    axis_t       r;
    logic [10:0] p11, nx;
    p11      = {1'b0, pos};
    nx       = '0;
    r.pos    = pos;
    r.neg    = neg;
    r.bounce = 1'b0;
    if (!neg) begin
      nx = p11 + STEP11;
      if (nx > lim) begin
        r.pos    = lim[PIX_W-1:0];
        r.neg    = 1'b1;
        r.bounce = 1'b1;
      end else begin
        r.pos = nx[PIX_W-1:0];
      end
    end else if (p11 < STEP11) begin
      r.pos    = '0;
      r.neg    = 1'b0;
      r.bounce = 1'b1;
    end else begin
      nx    = p11 - STEP11;
      r.pos = nx[PIX_W-1:0];
    end
    return r;
  endfunction

  always_comb begin
    mode_w = mode_e'(mode);
    move_x = (mode_w == MODE_XBOUNCE) || (mode_w == MODE_DIAG);
    move_y = (mode_w == MODE_YBOUNCE) || (mode_w == MODE_DIAG);
    ax_d   = '{bounce: 1'b0, neg: dx_neg_q, pos: x_q};
    ay_d   = '{bounce: 1'b0, neg: dy_neg_q, pos: y_q};
    if (move_x) ax_d = axis_next(x_q, dx_neg_q, X_MAX);
    if (move_y) ay_d = axis_next(y_q, dy_neg_q, Y_MAX);
  end

  // Offsets wrap far above the sprite size when the pixel lies left of or
  // above the box, so one unsigned compare per axis is the whole in-box test.
  always_comb begin
    col_off     = {1'b0, pix_x} - {1'b0, x_q};
    row_off     = {1'b0, pix_y} - {1'b0, y_q};
    in_box      = (col_off < 11'(SPRITE_W)) && (row_off < 11'(SPRITE_H));
    col_idx     = COL_W'(SPRITE_W - 1) - col_off[COL_W-1:0];
    sprite_on_d = in_box && rom_row[col_idx] && video_on;
  end

  digit_glyph_rom #(
    .SPRITE_W (SPRITE_W)
  ) u_rom (
    .digit    (digit_q),
    .row      (row_off[3:0]),
    .row_data (rom_row)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= X_HOME;
      y_q         <= Y_HOME;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      digit_q     <= '0;
      hit_q       <= 1'b0;
      sprite_on_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      sprite_on_q <= sprite_on_d;
      rgb_q       <= sprite_on_d ? COLOR : RGB_BLACK;
      hit_q       <= 1'b0;
      if (refr_tick) digit_q <= digit;
      if (go_home) begin
        x_q      <= X_HOME;
        y_q      <= Y_HOME;
        dx_neg_q <= 1'b0;
        dy_neg_q <= 1'b0;
      end else if (refr_tick) begin
        x_q      <= ax_d.pos;
        y_q      <= ay_d.pos;
        dx_neg_q <= ax_d.neg;
        dy_neg_q <= ay_d.neg;
        hit_q    <= ax_d.bounce | ay_d.bounce;
      end
    end
  end

  assign sprite_on  = sprite_on_q;
  assign sprite_rgb = rgb_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_digit_sprite_engine.sv
// Directed bench for digit_sprite_engine: pixel expectations go through a
// scoreboard queue and are popped one clock after the pixel is driven.
module tb_digit_sprite_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_on;
  logic       refr_tick;
  logic [9:0] pix_x, pix_y;
  logic [3:0] digit;
  logic [1:0] mode;
  logic       go_home;
  logic       sprite_on;
  logic [2:0] sprite_rgb;
  logic [9:0] x_pos, y_pos;
  logic       hit;

  int total = 0;
  int bad   = 0;

  logic sb[$];

  always #5 clk = ~clk;

  digit_sprite_engine dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .refr_tick  (refr_tick),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .digit      (digit),
    .mode       (mode),
    .go_home    (go_home),
    .sprite_on  (sprite_on),
    .sprite_rgb (sprite_rgb),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .hit        (hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic v, input logic exp);
    logic e;
    @(negedge clk);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = v;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("sprite_on@%0d,%0d", x, y), 32'(sprite_on), 32'(e));
    check($sformatf("sprite_rgb@%0d,%0d", x, y), 32'(sprite_rgb), e ? 32'd5 : 32'd0);
  endtask

  task automatic tick(output logic h);
    @(negedge clk);
    refr_tick = 1'b1;
    @(posedge clk);
    #1;
    h = hit;
    @(negedge clk);
    refr_tick = 1'b0;
  endtask

  task automatic ticks(input int n, output logic any_hit);
    logic h;
    any_hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(h);
      any_hit = any_hit | h;
    end
  endtask

  task automatic home(input logic with_tick);
    @(negedge clk);
    go_home   = 1'b1;
    refr_tick = with_tick;
    @(posedge clk);
    #1;
    check("home_x", 32'(x_pos), 32'd300);
    check("home_y", 32'(y_pos), 32'd10);
    check("home_hit", 32'(hit), 32'd0);
    @(negedge clk);
    go_home   = 1'b0;
    refr_tick = 1'b0;
  endtask

  task automatic pos(input string tag, input int ex, input int ey);
    check({tag, "_x"}, 32'(x_pos), 32'(ex));
    check({tag, "_y"}, 32'(y_pos), 32'(ey));
  endtask

  initial begin
    logic h;
    reset = 1'b1; video_on = 1'b0; refr_tick = 1'b0;
    pix_x = '0; pix_y = '0; digit = '0; mode = 2'b00; go_home = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    pos("reset", 300, 10);
    check("reset_on", 32'(sprite_on), 32'd0);
    check("reset_rgb", 32'(sprite_rgb), 32'd0);
    check("reset_hit", 32'(hit), 32'd0);

    // Static digit 6; row 0 lit for columns 12..19 only.
    digit = 4'd6;
    tick(h);
    check("static_hit", 32'(h), 32'd0);
    pos("static", 300, 10);
    for (int x = 296; x <= 335; x++) pix(x, 10, 1'b1, (x >= 312) && (x <= 319));
    pix(315, 10, 1'b0, 1'b0);
    pix(315, 9, 1'b1, 1'b0);
    pix(315, 26, 1'b1, 1'b0);

    // X bounce from home.
    mode = 2'b01;
    ticks(308, h);
    check("x308_hit", 32'(h), 32'd0);
    pos("x308", 608, 10);
    tick(h);
    check("x309_hit", 32'(h), 32'd1);
    pos("x309", 608, 10);
    @(posedge clk); #1;
    check("x309_hit_drop", 32'(hit), 32'd0);
    tick(h);
    pos("x310", 607, 10);

    // Y bounce off the bottom, back to the top, bounce off 0.
    mode = 2'b10;
    ticks(454, h);
    check("ydown_hit", 32'(h), 32'd0);
    pos("ydown", 607, 464);
    tick(h);
    check("ybot_hit", 32'(h), 32'd1);
    pos("ybot", 607, 464);
    ticks(464, h);
    check("yup_hit", 32'(h), 32'd0);
    pos("yup", 607, 0);
    tick(h);
    check("ytop_hit", 32'(h), 32'd1);
    pos("ytop", 607, 0);
    tick(h);
    check("ytop_next_hit", 32'(h), 32'd0);
    pos("ytop_next", 607, 1);

    // Diagonal into the bottom-right corner.
    home(1'b0);
    ticks(146, h);
    pos("ypre", 300, 156);
    mode = 2'b11;
    ticks(308, h);
    check("diag_hit", 32'(h), 32'd0);
    pos("diag", 608, 464);
    tick(h);
    check("corner_hit", 32'(h), 32'd1);
    pos("corner", 608, 464);
    @(posedge clk); #1;
    check("corner_single_pulse", 32'(hit), 32'd0);
    tick(h);
    pos("corner_next", 607, 463);

    // go_home wins over a simultaneous tick; directions return to +.
    home(1'b1);
    tick(h);
    pos("after_home", 301, 11);

    // Glyph change waits for the next tick.
    mode = 2'b00;
    home(1'b0);
    digit = 4'd12;
    for (int x = 310; x <= 321; x++) pix(x, 10, 1'b1, (x >= 312) && (x <= 319));
    tick(h);
    pos("blank", 300, 10);
    for (int y = 9; y <= 26; y++)
      for (int x = 299; x <= 332; x++) pix(x, y, 1'b1, 1'b0);

    // Asynchronous reset mid-frame.
    digit = 4'd6;
    mode  = 2'b01;
    tick(h);
    pos("pre_reset", 301, 10);
    pix(313, 10, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_on", 32'(sprite_on), 32'd0);
    check("async_rgb", 32'(sprite_rgb), 32'd0);
    pos("async", 300, 10);
    @(negedge clk);
    reset = 1'b0;
    mode  = 2'b00;
    @(posedge clk); #1;
    pos("post_reset", 300, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_sprite_engine.md
# digit_sprite_engine

Parametrised VGA sprite renderer. It draws one 32x16 digit glyph (0–9) selected at run time. The sprite can stay static or bounce around the screen, moving in x, y or both on each `refr_tick`. It sits beside the pixel generator and feeds the RGB mux with `sprite_on`/`sprite_rgb`, one cycle behind `pix_x`/`pix_y`.

## Interface
- `SPRITE_W`, 32, glyph width in pixels (ROM row width)
- `SPRITE_H`, 16, glyph height in rows
- `SCREEN_W`, 640, visible width
- `SCREEN_H`, 480, visible height
- `X_INIT`, 300, home x (left edge)
- `Y_INIT`, 10, home y (top edge)
- `STEP`, 1, pixels moved per `refr_tick` per moving axis
- `COLOR`, 3'b101, sprite colour
- `clk` in 1: pixel clock
- `reset` in 1: asynchronous, active-high
- `video_on` in 1: visible-area flag, aligned with `pix_x`/`pix_y`
- `refr_tick` in 1: one-cycle pulse, once per frame
- `pix_x` in 10: current pixel column
- `pix_y` in 10: current pixel row
- `digit` in 4: glyph select; values 10–15 select a blank glyph
- `mode` in 2: 00 static, 01 x-bounce, 10 y-bounce, 11 diagonal
- `go_home` in 1: reload home position and + directions
- `sprite_on` out 1: pixel belongs to the lit glyph
- `sprite_rgb` out 3: `COLOR` when `sprite_on`, else 0
- `x_pos` out 10: current left edge
- `y_pos` out 10: current top edge
- `hit` out 1: one-cycle pulse on an edge bounce

## Operation
- State registers: `x_reg`, `y_reg`, `dx_neg`, `dy_neg`, `digit_reg`.
- Reset values:
  - `x_reg`=`X_INIT`, `y_reg`=`Y_INIT`
  - `dx_neg`=`dy_neg`=0
  - `digit_reg`=0
  - `sprite_on`=0, `sprite_rgb`=0, `hit`=0
- `digit` is sampled into `digit_reg` only on `refr_tick`, so a glyph change never tears mid-frame.
- On `refr_tick`, an axis moves only if its mode bit is set (bit0 = x, bit1 = y).
- Moving +: next = x+`STEP`. If next > `SCREEN_W`-`SPRITE_W`:
  - x = `SCREEN_W`-`SPRITE_W`
  - `dx_neg` becomes 1
  - bounce is flagged
- Moving −: if x < `STEP`, then x = 0, `dx_neg` becomes 0, bounce is flagged; else x = x−`STEP`.
- The y axis follows the same rules using `SCREEN_H`/`SPRITE_H`.
- Arithmetic uses 11-bit intermediates, so no wrap-around is possible.
- `hit` is asserted for the cycle after a `refr_tick` on which either axis bounced. A simultaneous x and y bounce gives a single pulse.
- `go_home` reloads the home position and clears both directions. It has priority over `refr_tick` in the same cycle and does not alter `digit_reg`.
- A mode change takes effect at the next `refr_tick`. Direction bits are preserved across mode changes.
- In-box test: `x_reg` ≤ `pix_x` ≤ `x_reg`+`SPRITE_W`−1, and likewise for y.
- Row/column offsets are full-width subtractions (`pix` − `reg`), not low-bit truncations.
- Column c maps to ROM bit `SPRITE_W`−1−c, so the MSB is the leftmost pixel.
- `sprite_on` = in-box & ROM bit & `video_on`.

## Timing
- Pixel path latency is exactly 1 clk. `sprite_on`/`sprite_rgb` are registered from the pixel inputs of the previous cycle.
- Position updates are visible on `x_pos`/`y_pos` the cycle after `refr_tick` (or `go_home`).
- Reset mid-frame: outputs clear immediately (asynchronous). The position reloads to home.

## Structure
- Shared package `vga_pkg`:
  - `SCREEN_W`, `SCREEN_H`
  - pixel coordinate width (10)
  - colour constants
  - mode encodings
- One sub-module, `digit_glyph_rom`:
  - inputs: `digit[3:0]`, `row[3:0]`
  - output: `SPRITE_W`-bit row data
  - purely combinational case ROM
  - default row is 0

## Test plan
- Reset, then release. Expect `x_pos`=300, `y_pos`=10, `sprite_on`=0, `hit`=0.
- Static mode, `digit`=6, one `refr_tick`. Glyph '6' row 0 = 0x000FF000.
  - Scan `pix_y`=10, `pix_x` 300–331 → `sprite_on`=1 exactly for `pix_x` 312–319, each one cycle late.
  - `video_on`=0 → `sprite_on`=0.
- `mode`=01 from home:
  - After 308 ticks, `x_pos`=608 with no `hit`.
  - Tick 309: `x_pos`=608, `hit` pulses, direction becomes −.
  - Tick 310: `x_pos`=607.
- `mode`=10 with the sprite near the top moving −:
  - From `y_pos`=0 → bounce, `y_pos`=0, `hit`.
  - `mode`=11 at corner (608,464) → single `hit` pulse; both directions flip.
- `go_home` and `refr_tick` in the same cycle while moving → position becomes (300,10) and both directions +.
- Change `digit` from 6 to 12 between ticks:
  - Glyph unchanged until the next `refr_tick`.
  - Then `sprite_on` stays 0 over the whole box.
